access_sequencer: RTL
=====================

# access_sequencer

Parametrised successor to the station controller FSM: sequences one person through temperature check, gel dispensing and door release, and raises an alarm with a latched cause on fever, abandonment or timeout. It sits between the UART receiver (temperature verdict bytes), the dispenser (gel request/done) and the buzzer/door drivers. It also tracks room occupancy against a configurable capacity and refuses new entries when full.

## Interface
- CNT_W, 8: occupancy counter width
- MAX_OCC, 20: room capacity, 1 ≤ MAX_OCC ≤ 2^CNT_W−1
- TEMP_TIMEOUT, 50_000_000: max cycles in TEMP waiting for a verdict byte
- GEL_TIMEOUT, 25_000_000: max cycles in GEL waiting for gel_done
- DOOR_CYCLES, 100_000_000: cycles the door stays released
- ALARM_MIN, 50_000_000: minimum cycles alarm stays asserted before ack is honoured
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high
- presence  in  1  person detected at station (level, pre-synchronised)
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  verdict byte: 8'h02 temp OK, 8'h01 fever; other values ignored
- gel_done  in  1  one-cycle pulse from dispenser
- exit_pulse  in  1  one-cycle pulse, person left the room
- ack  in  1  operator acknowledge (level, pre-synchronised)
- gel_req  out  1  high in GEL
- door_open  out  1  high in OPEN
- alarm  out  1  high in ALARM
- full  out  1  occupancy == MAX_OCC
- alarm_cause  out  2  0 none, 1 fever, 2 presence lost, 3 timeout; latched
- state  out  3  current state encoding
- occupancy  out  CNT_W  persons inside

## Operation
- States: IDLE=0, TEMP=1, GEL=2, OPEN=3, ALARM=4; codes 5–7 → IDLE next cycle.
- IDLE: presence & !full → TEMP. Timer cleared on every state change.
- TEMP: priority: !presence → ALARM cause 2; rx_valid & rx_data==8'h01 → ALARM cause 1; rx_valid & 8'h02 → GEL; timer == TEMP_TIMEOUT−1 → ALARM cause 3.
- GEL: priority: !presence → ALARM cause 2; gel_done → OPEN; timer == GEL_TIMEOUT−1 → ALARM cause 3. rx_valid ignored.
- OPEN: after DOOR_CYCLES cycles → IDLE, occupancy +1 on that transition. presence ignored.
- ALARM: timer counts up, saturates at ALARM_MIN; when timer ≥ ALARM_MIN−1 and ack → IDLE. ack earlier ignored. alarm_cause cleared on ALARM→IDLE.
- exit_pulse: occupancy −1 in any state; at 0 ignored (saturate). Simultaneous +1 and −1: unchanged.
- full recomputed combinationally from registered occupancy.

## Timing
- Reset: state=IDLE, timer=0, occupancy=0, alarm_cause=0; gel_req, door_open, alarm, full all 0 on first cycle after reset. Reset mid-operation aborts immediately, including occupancy.
- Moore outputs: gel_req/door_open/alarm decoded from registered state; they change the cycle after the triggering input is sampled.
- alarm_cause updates on the same edge that enters ALARM.
- Timeout: entering TEMP at edge k with no events → state=ALARM after edge k+TEMP_TIMEOUT.
- door_open high exactly DOOR_CYCLES cycles; occupancy increments on the edge door_open falls.
- Minimum ALARM dwell: ALARM_MIN cycles with ack held high.

## Structure
- Shared package: state encoding constants, alarm_cause codes, verdict byte constants (8'h01, 8'h02).
- Single timer register of width $clog2 of the largest timeout parameter, shared by all states.
- Occupancy counter is a natural sub-module: occ_counter (inc, dec, saturate 0/MAX, full flag).

## Test plan
- Reduced params (timeouts 8, DOOR 4, ALARM_MIN 6, MAX_OCC 2): presence, rx 8'h02, gel_done → door_open high 4 cycles, occupancy 0→1.
- presence, rx 8'h01 → alarm=1, cause=1; ack at cycle 2 of ALARM ignored; ack held → IDLE after 6 cycles, cause=0.
- presence dropped in GEL → ALARM cause 2; no gel_done for 8 cycles in GEL → ALARM cause 3.
- Two full passes → full=1, presence ignored in IDLE; exit_pulse → occupancy 1, full=0, next entry accepted.
- exit_pulse on the same edge as OPEN→IDLE → occupancy unchanged; exit_pulse at 0 → stays 0.
- Reset asserted in OPEN with occupancy 1 → all outputs 0, occupancy 0 next cycle; rx byte 8'h55 in TEMP ignored.

Source files
------------

// File: rtl/access_sequencer_pkg.sv
// Shared definitions for the access sequencer: state encoding, alarm cause
// codes, UART verdict byte values and a small helper used to size the
// shared timer.
package access_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TEMP  = 3'd1,
        ST_GEL   = 3'd2,
        ST_OPEN  = 3'd3,
        ST_ALARM = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_FEVER   = 2'd1,
        CAUSE_LOST    = 2'd2,
        CAUSE_TIMEOUT = 2'd3
    } cause_t;

    localparam logic [7:0] VERDICT_FEVER = 8'h01;
    localparam logic [7:0] VERDICT_OK    = 8'h02;

    // Largest of four cycle-count parameters; sizes the shared timer.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/access_sequencer_occ_counter.sv
// Room occupancy counter.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   inc, dec   : one-cycle increment / decrement requests
//   count      : persons inside (saturates at 0 and MAX_OCC)
//   full       : count == MAX_OCC, decoded from the registered count
module access_sequencer_occ_counter #(
    parameter int CNT_W   = 8,
    parameter int MAX_OCC = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_OCC);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // Simultaneous inc and dec cancel out, even at either bound.
    always_comb begin
        count_next = count_reg;
        if (inc && !dec && (count_reg != MAX_VAL)) begin
            count_next = count_reg + CNT_W'(1);
        end else if (dec && !inc && (count_reg != '0)) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
    assign full  = (count_reg == MAX_VAL);

endmodule

// File: rtl/access_sequencer.sv
// Station access sequencer: walks one person through temperature check,
// gel dispensing and door release, raising an alarm with a latched cause on
// fever, presence loss or timeout. Tracks room occupancy and refuses new
// entries while the room is full.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   presence     : person at station (level)
//   rx_valid     : strobe qualifying rx_data (verdict byte)
//   rx_data      : 8'h02 temperature OK, 8'h01 fever, others ignored
//   gel_done     : dispenser finished pulse
//   exit_pulse   : person left the room pulse
//   ack          : operator acknowledge (level)
//   gel_req      : high in GEL
//   door_open    : high in OPEN
//   alarm        : high in ALARM
//   full         : occupancy == MAX_OCC
//   alarm_cause  : 0 none, 1 fever, 2 presence lost, 3 timeout (latched)
//   state        : current state encoding
//   occupancy    : persons inside
module access_sequencer
    import access_sequencer_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int MAX_OCC      = 20,
    parameter int TEMP_TIMEOUT = 50_000_000,
    parameter int GEL_TIMEOUT  = 25_000_000,
    parameter int DOOR_CYCLES  = 100_000_000,
    parameter int ALARM_MIN    = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             presence,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             gel_done,
    input  logic             exit_pulse,
    input  logic             ack,
    output logic             gel_req,
    output logic             door_open,
    output logic             alarm,
    output logic             full,
    output logic [1:0]       alarm_cause,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] occupancy
);

    // The ALARM timer saturates at ALARM_MIN itself, so the width must hold
    // the largest parameter value, not just that value minus one.
    localparam int MAX_T = max4(TEMP_TIMEOUT, GEL_TIMEOUT, DOOR_CYCLES, ALARM_MIN);
    localparam int TW    = (MAX_T < 2) ? 1 : $clog2(MAX_T + 1);

    localparam logic [TW-1:0] TEMP_LAST  = TW'(TEMP_TIMEOUT - 1);
    localparam logic [TW-1:0] GEL_LAST   = TW'(GEL_TIMEOUT - 1);
    localparam logic [TW-1:0] DOOR_LAST  = TW'(DOOR_CYCLES - 1);
    localparam logic [TW-1:0] ALARM_LAST = TW'(ALARM_MIN - 1);
    localparam logic [TW-1:0] ALARM_SAT  = TW'(ALARM_MIN);

    state_t        state_reg, state_next;
    cause_t        cause_reg, cause_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic          occ_inc;
    logic          full_w;

    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        occ_inc    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (presence && !full_w) begin
                    state_next = ST_TEMP;
                end
            end
            ST_TEMP: begin
                if (!presence) begin
                    state_next = ST_ALARM;
                    cause_next = CAUSE_LOST;
                end else if (rx_valid && (rx_data == VERDICT_FEVER)) begin
                    state_next = ST_ALARM;
                    cause_next = CAUSE_FEVER;
                end else if (rx_valid && (rx_data == VERDICT_OK)) begin
                    state_next = ST_GEL;
                end else if (timer_reg == TEMP_LAST) begin
                    state_next = ST_ALARM;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            ST_GEL: begin
                if (!presence) begin
                    state_next = ST_ALARM;
                    cause_next = CAUSE_LOST;
                end else if (gel_done) begin
                    state_next = ST_OPEN;
                end else if (timer_reg == GEL_LAST) begin
                    state_next = ST_ALARM;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            ST_OPEN: begin
                if (timer_reg == DOOR_LAST) begin
                    state_next = ST_IDLE;
                    occ_inc    = 1'b1;
                end
            end
            ST_ALARM: begin
                if ((timer_reg >= ALARM_LAST) && ack) begin
                    state_next = ST_IDLE;
                    cause_next = CAUSE_NONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // One timer shared by all states, cleared on every state change. IDLE
    // holds it at zero; ALARM saturates it so it never wraps while waiting
    // for an operator.
    always_comb begin
        timer_next = timer_reg + TW'(1);
        if (state_next != state_reg) begin
            timer_next = '0;
        end else if (state_reg == ST_IDLE) begin
            timer_next = '0;
        end else if ((state_reg == ST_ALARM) && (timer_reg >= ALARM_SAT)) begin
            timer_next = ALARM_SAT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cause_reg <= CAUSE_NONE;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            cause_reg <= cause_next;
            timer_reg <= timer_next;
        end
    end

    access_sequencer_occ_counter #(
        .CNT_W   (CNT_W),
        .MAX_OCC (MAX_OCC)
    ) u_occ (
        .clk   (clk),
        .reset (reset),
        .inc   (occ_inc),
        .dec   (exit_pulse),
        .count (occupancy),
        .full  (full_w)
    );

    assign full        = full_w;
    assign gel_req     = (state_reg == ST_GEL);
    assign door_open   = (state_reg == ST_OPEN);
    assign alarm       = (state_reg == ST_ALARM);
    assign alarm_cause = cause_reg;
    assign state       = state_reg;

endmodule
